// File: rtl/loss_pair_feeder_pkg.sv
// Shared definitions for the loss pair feeder: data width and controller states.
package loss_pair_feeder_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/loss_pair_feeder_fifo.sv
// Registered synchronous FIFO (no fall-through) with full/empty flags and an
// overflow strobe for pushes attempted while full.
module loss_pair_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              push_valid,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop_ok;

    // Full is taken from occupancy alone, so a same-cycle pop never frees a slot.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = push_valid & ~full;
    assign pop_ok   = pop & ~empty;
    assign overflow = push_valid & full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/loss_pair_feeder.sv
// Joins prediction (H) and target (Y) streams into aligned pairs, issuing one
// batch per start command and pulsing done alongside the final pair.
module loss_pair_feeder
    import loss_pair_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      h_data_in,
    input  logic             h_valid_in,
    output logic             h_ready_out,
    input  logic [15:0]      y_data_in,
    input  logic             y_valid_in,
    output logic             y_ready_out,
    input  logic             cfg_load_in,
    input  logic [CNT_W-1:0] cfg_batch_size_in,
    input  logic [15:0]      cfg_inv_in,
    input  logic             start_in,
    output logic [15:0]      H_out,
    output logic [15:0]      Y_out,
    output logic [15:0]      inv_batch_size_times_two_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             overflow_err_out
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  batch_size;
    logic [15:0]       inv;

    logic [DATA_W-1:0] h_head;
    logic [DATA_W-1:0] y_head;
    logic              h_full, h_empty, h_ovf;
    logic              y_full, y_empty, y_ovf;
    logic              pop;
    logic              last_pop;
    logic [CNT_W-1:0]  start_size;

    loss_pair_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_h_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (h_data_in),
        .push_valid (h_valid_in),
        .pop        (pop),
        .head       (h_head),
        .full       (h_full),
        .empty      (h_empty),
        .overflow   (h_ovf)
    );

    loss_pair_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_y_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (y_data_in),
        .push_valid (y_valid_in),
        .pop        (pop),
        .head       (y_head),
        .full       (y_full),
        .empty      (y_empty),
        .overflow   (y_ovf)
    );

    assign pop        = (state == RUN) && !h_empty && !y_empty && (cnt < batch_size);
    assign last_pop   = pop && (cnt == batch_size - CNT_W'(1));
    // A load coinciding with start governs that start's batch size.
    assign start_size = cfg_load_in ? cfg_batch_size_in : batch_size;

    assign h_ready_out                  = ~h_full;
    assign y_ready_out                  = ~y_full;
    assign busy_out                     = (state != IDLE);
    assign done_out                     = (state == DONE);
    assign inv_batch_size_times_two_out = inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            batch_size       <= '0;
            inv              <= '0;
            H_out            <= '0;
            Y_out            <= '0;
            valid_out        <= 1'b0;
            overflow_err_out <= 1'b0;
        end else begin
            valid_out <= pop;
            if (pop) begin
                H_out <= h_head;
                Y_out <= y_head;
            end
            if (h_ovf || y_ovf) begin
                overflow_err_out <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_load_in) begin
                        batch_size <= cfg_batch_size_in;
                        inv        <= cfg_inv_in;
                    end
                    if (start_in && (start_size != '0)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (pop) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_pop) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loss_pair_feeder.sv
// Self-checking bench for loss_pair_feeder: vector table, directed corner
// sequences and a random phase, all cross-checked by a queue-based reference model.
module tb_loss_pair_feeder;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      h_data_in;
    logic             h_valid_in;
    logic             h_ready_out;
    logic [15:0]      y_data_in;
    logic             y_valid_in;
    logic             y_ready_out;
    logic             cfg_load_in;
    logic [CNT_W-1:0] cfg_batch_size_in;
    logic [15:0]      cfg_inv_in;
    logic             start_in;
    logic [15:0]      H_out;
    logic [15:0]      Y_out;
    logic [15:0]      inv_out;
    logic             valid_out;
    logic             busy_out;
    logic             done_out;
    logic             overflow_err_out;

    always #5 clk = ~clk;

    loss_pair_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .h_data_in                    (h_data_in),
        .h_valid_in                   (h_valid_in),
        .h_ready_out                  (h_ready_out),
        .y_data_in                    (y_data_in),
        .y_valid_in                   (y_valid_in),
        .y_ready_out                  (y_ready_out),
        .cfg_load_in                  (cfg_load_in),
        .cfg_batch_size_in            (cfg_batch_size_in),
        .cfg_inv_in                   (cfg_inv_in),
        .start_in                     (start_in),
        .H_out                        (H_out),
        .Y_out                        (Y_out),
        .inv_batch_size_times_two_out (inv_out),
        .valid_out                    (valid_out),
        .busy_out                     (busy_out),
        .done_out                     (done_out),
        .overflow_err_out             (overflow_err_out)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: two queues, a batch-in-progress flag and a pair counter.
    logic [15:0] mhq [$];
    logic [15:0] myq [$];
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_issued = 0;
    int          m_bsz = 0;
    logic [15:0] m_inv = '0;
    logic [15:0] m_h = '0;
    logic [15:0] m_y = '0;

    always @(posedge clk) begin : model
        int hs;
        int ys;
        if (rst) begin
            mhq.delete();
            myq.delete();
            m_run = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_issued = 0; m_bsz = 0; m_inv = '0; m_h = '0; m_y = '0;
        end else begin
            hs = mhq.size();
            ys = myq.size();
            m_valid = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_run) begin
                if (hs > 0 && ys > 0) begin
                    m_h = mhq.pop_front();
                    m_y = myq.pop_front();
                    m_valid = 1'b1;
                    m_issued++;
                    if (m_issued == m_bsz) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else begin
                if (cfg_load_in) begin
                    m_bsz = int'(cfg_batch_size_in);
                    m_inv = cfg_inv_in;
                end
                if (start_in && m_bsz != 0) begin
                    m_run    = 1'b1;
                    m_issued = 0;
                end
            end
            if (h_valid_in) begin
                if (hs < DEPTH) mhq.push_back(h_data_in);
                else m_ovf = 1'b1;
            end
            if (y_valid_in) begin
                if (ys < DEPTH) myq.push_back(y_data_in);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("model",
                  {valid_out, H_out, Y_out, inv_out, busy_out, done_out,
                   h_ready_out, y_ready_out, overflow_err_out},
                  {m_valid, m_h, m_y, m_inv, m_run | m_done, m_done,
                   mhq.size() < DEPTH, myq.size() < DEPTH, m_ovf});
        end
    end

    typedef struct {
        logic        rst, hv, yv, load, start;
        logic [15:0] hd, yd, inv;
        logic [7:0]  bsz;
        logic        ev, edone, ebusy;
        logic [15:0] eh, ey, einv;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic r, logic hv, logic [15:0] hd, logic yv, logic [15:0] yd,
                                logic ld, logic [7:0] bs, logic [15:0] iv, logic st,
                                logic ev, logic [15:0] eh, logic [15:0] ey,
                                logic edn, logic eb, logic [15:0] einv);
        vec_t v;
        v.rst = r; v.hv = hv; v.hd = hd; v.yv = yv; v.yd = yd;
        v.load = ld; v.bsz = bs; v.inv = iv; v.start = st;
        v.ev = ev; v.eh = eh; v.ey = ey; v.edone = edn; v.ebusy = eb; v.einv = einv;
        return v;
    endfunction

    logic [15:0] got_h [16];
    logic [15:0] got_y [16];
    int          got_n;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; h_valid_in = 1'b0; y_valid_in = 1'b0;
        cfg_load_in = 1'b0; start_in = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_pairs(input int n, input logic [15:0] hb, input logic [15:0] yb);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            h_valid_in = 1'b1; h_data_in = hb + 16'(i);
            y_valid_in = 1'b1; y_data_in = yb + 16'(i);
            tick();
        end
        idle_inputs();
    endtask

    // Starts a batch, collects the issued pairs until done, then returns in IDLE.
    task automatic run_batch(input bit load, input logic [7:0] bsz);
        bit seen_done;
        seen_done = 1'b0;
        got_n = 0;
        idle_inputs();
        start_in = 1'b1; cfg_load_in = load;
        cfg_batch_size_in = bsz; cfg_inv_in = 16'h0100;
        tick();
        idle_inputs();
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (valid_out && got_n < 16) begin
                got_h[got_n] = H_out;
                got_y[got_n] = Y_out;
                got_n++;
            end
            if (done_out) seen_done = 1'b1;
        end
        check("batch_done_seen", 64'(seen_done), 64'd1);
        tick();
    endtask

    initial begin
        int first, nval, last_c;

        // Basic batch of 4 with prefetched data, one row per clock.
        tbl[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        tbl[1]  = mk(0, 1, 16'h0100, 1, 16'h0080, 1, 8'd4, 16'h0080, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0080);
        tbl[2]  = mk(0, 1, 16'h0200, 1, 16'h0200, 0, 8'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0080);
        tbl[3]  = mk(0, 1, 16'hFF00, 1, 16'h0100, 0, 8'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0080);
        tbl[4]  = mk(0, 1, 16'h0080, 1, 16'h0000, 0, 8'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0080);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 16'h0080);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 0, 1, 16'h0100, 16'h0080, 0, 1, 16'h0080);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 0, 1, 16'h0200, 16'h0200, 0, 1, 16'h0080);
        tbl[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 0, 1, 16'hFF00, 16'h0100, 0, 1, 16'h0080);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 0, 1, 16'h0080, 16'h0000, 1, 1, 16'h0080);
        tbl[10] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 8'd0, 16'h0000, 0, 0, 16'h0080, 16'h0000, 0, 0, 16'h0080);

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; h_valid_in = tbl[i].hv; h_data_in = tbl[i].hd;
            y_valid_in = tbl[i].yv; y_data_in = tbl[i].yd;
            cfg_load_in = tbl[i].load; cfg_batch_size_in = tbl[i].bsz;
            cfg_inv_in = tbl[i].inv; start_in = tbl[i].start;
            tick();
            check($sformatf("vec%0d", i),
                  64'({valid_out, H_out, Y_out, done_out, busy_out, inv_out,
                       h_ready_out, y_ready_out, overflow_err_out}),
                  64'({tbl[i].ev, tbl[i].eh, tbl[i].ey, tbl[i].edone, tbl[i].ebusy,
                       tbl[i].einv, 1'b1, 1'b1, 1'b0}));
            if (i == 0) mon_en = 1'b1;
        end

        // Y lags H by ten cycles; no pair may issue before Y arrives.
        first = -1; nval = 0; last_c = -1;
        for (int t = 0; t < 20; t++) begin
            idle_inputs();
            if (t == 0) begin
                cfg_load_in = 1'b1; cfg_batch_size_in = 8'd3;
                cfg_inv_in = 16'h0040; start_in = 1'b1;
            end
            if (t <= 2) begin h_valid_in = 1'b1; h_data_in = 16'h1000 + 16'(t); end
            if (t >= 10 && t <= 12) begin y_valid_in = 1'b1; y_data_in = 16'h2000 + 16'(t); end
            tick();
            if (valid_out) begin
                if (first < 0) first = t + 1;
                nval++;
                last_c = t + 1;
            end
        end
        check("lag_first_cycle", 64'(first), 64'd12);
        check("lag_pair_count", 64'(nval), 64'd3);
        check("lag_last_cycle", 64'(last_c), 64'd14);

        // Overflow: eight H entries fill the FIFO, a ninth is dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            h_valid_in = 1'b1; h_data_in = 16'h3000 + 16'(i);
            tick();
        end
        check("ovf_ready_after_8", 64'(h_ready_out), 64'd0);
        check("ovf_not_yet", 64'(overflow_err_out), 64'd0);
        idle_inputs();
        h_valid_in = 1'b1; h_data_in = 16'h3999;
        tick();
        check("ovf_set", 64'(overflow_err_out), 64'd1);
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            y_valid_in = 1'b1; y_data_in = 16'h3100 + 16'(i);
            tick();
        end
        run_batch(1'b1, 8'd8);
        check("ovf_pair_count", 64'(got_n), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_h%0d", i), 64'(got_h[i]), 64'(16'h3000 + 16'(i)));
        end
        check("ovf_sticky", 64'(overflow_err_out), 64'd1);
        do_reset();
        check("ovf_cleared", 64'(overflow_err_out), 64'd0);

        // Zero batch size start is ignored; a load during RUN must not take effect.
        start_in = 1'b1;
        tick();
        idle_inputs();
        check("bsz0_not_busy", 64'(busy_out), 64'd0);
        tick();
        check("bsz0_still_idle", 64'(busy_out), 64'd0);
        cfg_load_in = 1'b1; cfg_batch_size_in = 8'd3; cfg_inv_in = 16'h0011; start_in = 1'b1;
        tick();
        check("run_busy", 64'(busy_out), 64'd1);
        idle_inputs();
        cfg_load_in = 1'b1; cfg_batch_size_in = 8'd1; cfg_inv_in = 16'h7777;
        tick();
        check("run_inv_held", 64'(inv_out), 64'h0011);
        nval = 0;
        for (int t = 0; t < 12; t++) begin
            idle_inputs();
            if (t < 3) begin
                h_valid_in = 1'b1; h_data_in = 16'h0A00 + 16'(t);
                y_valid_in = 1'b1; y_data_in = 16'h0B00 + 16'(t);
            end
            tick();
            if (valid_out) nval++;
        end
        check("run_load_count", 64'(nval), 64'd3);
        check("run_inv_after", 64'(inv_out), 64'h0011);
        push_pairs(3, 16'h0C00, 16'h0D00);
        run_batch(1'b0, 8'd0);
        check("run_bsz_kept", 64'(got_n), 64'd3);

        // Reset mid-batch: two of four pairs issued, three left queued.
        do_reset();
        push_pairs(5, 16'h4000, 16'h5000);
        cfg_load_in = 1'b1; cfg_batch_size_in = 8'd4; cfg_inv_in = 16'h0022; start_in = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        check("mid_second_pair", 64'({valid_out, H_out}), 64'({1'b1, 16'h4001}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_outs",
              64'({valid_out, H_out, Y_out, done_out, busy_out, inv_out,
                   h_ready_out, y_ready_out, overflow_err_out}),
              64'({1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0}));
        push_pairs(2, 16'h6000, 16'h7000);
        run_batch(1'b1, 8'd2);
        check("mid_new_count", 64'(got_n), 64'd2);
        check("mid_new_pair0", 64'({got_h[0], got_y[0]}), 64'({16'h6000, 16'h7000}));
        check("mid_new_pair1", 64'({got_h[1], got_y[1]}), 64'({16'h6001, 16'h7001}));

        // Back-to-back batches of two drain pairs 0-3 and leave pair 4 queued.
        do_reset();
        push_pairs(5, 16'h8000, 16'h9000);
        run_batch(1'b1, 8'd2);
        check("b2a_count", 64'(got_n), 64'd2);
        check("b2a_pairs", 64'({got_h[0], got_h[1]}), 64'({16'h8000, 16'h8001}));
        run_batch(1'b0, 8'd0);
        check("b2b_count", 64'(got_n), 64'd2);
        check("b2b_pairs", 64'({got_h[0], got_y[1]}), 64'({16'h8002, 16'h9003}));
        run_batch(1'b1, 8'd1);
        check("b2_leftover", 64'({got_n[7:0], got_h[0], got_y[0]}), 64'({8'd1, 16'h8004, 16'h9004}));

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            h_valid_in = ($urandom_range(0, 1) == 1);
            y_valid_in = ($urandom_range(0, 1) == 1);
            h_data_in = 16'($urandom);
            y_data_in = 16'($urandom);
            cfg_load_in = ($urandom_range(0, 7) == 0);
            cfg_batch_size_in = 8'($urandom_range(0, 6));
            cfg_inv_in = 16'($urandom);
            start_in = ($urandom_range(0, 5) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loss_pair_feeder.md
Name: loss_pair_feeder

Overview:
- Upstream stage of the per-column loss gradient unit. Joins the prediction stream H (from the activation/output path) with the target stream Y (from the unified buffer) into aligned (H, Y) pairs.
- Each issued pair carries the held inv_batch_size_times_two constant.
- Issues exactly one batch of pairs per start command, then pulses done.
- Both input streams are buffered independently, so either side may run ahead of the other.

Parameters:
- DEPTH, 8: entries per input FIFO; power of two, at least 2.
- CNT_W, 8: width of the batch size and batch counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- h_data_in  in  16  signed fixed-point prediction
- h_valid_in  in  1  prediction push request
- h_ready_out  out  1  H FIFO not full
- y_data_in  in  16  signed fixed-point target
- y_valid_in  in  1  target push request
- y_ready_out  out  1  Y FIFO not full
- cfg_load_in  in  1  latch config (honoured in IDLE only)
- cfg_batch_size_in  in  CNT_W  pairs per batch
- cfg_inv_in  in  16  signed inv_batch_size_times_two value
- start_in  in  1  begin batch
- H_out  out  16  paired prediction
- Y_out  out  16  paired target
- inv_batch_size_times_two_out  out  16  held config value
- valid_out  out  1  pair valid
- busy_out  out  1  state is RUN or DONE
- done_out  out  1  one-cycle pulse after the last pair
- overflow_err_out  out  1  sticky: push attempted while FIFO full

Behaviour:
- Reset, synchronous on posedge clk while rst=1:
  - both FIFOs flushed; counters and config registers cleared; state IDLE.
  - every output 0 except h_ready_out=1 and y_ready_out=1.
  - Reset mid-batch discards everything, including stored entries.
- FIFOs:
  - Registered storage, no fall-through. A push at cycle t becomes visible at the head at t+1.
  - ready_out = not full, computed from occupancy only, independent of a same-cycle pop.
  - push = valid_in & ready_out. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
  - valid_in while full: data dropped, overflow_err_out set; it clears only on rst.
  - Pushes are accepted in every state, so inputs can prefetch while IDLE.
- Config:
  - cfg_load_in in IDLE latches batch_size and inv; ignored in RUN and DONE.
  - inv_batch_size_times_two_out always drives the latched inv.
- States:
  - IDLE -> RUN on start_in when latched batch_size != 0. If start_in coincides with cfg_load_in, the newly loaded values apply. start_in with batch_size=0 is ignored.
  - RUN: pop both FIFOs in the same cycle when both are non-empty and cnt < batch_size. Register H_out/Y_out from the heads; valid_out=1 the next cycle; cnt++.
  - RUN -> DONE in the cycle the pop with cnt == batch_size-1 occurs.
  - DONE: lasts 1 cycle. done_out=1 there, concurrent with the last valid_out. Then -> IDLE and cnt=0.
  - start_in outside IDLE is ignored.
- valid_out is 0 on every cycle without a pop. H_out/Y_out hold their last values when valid_out=0.
- No arithmetic on the data path. Data is passed bit-exact; the 16-bit signed fixed-point format is unchanged.
- Latency: push to valid_out is 2 cycles minimum (push at t, pop at t+1, valid_out at t+2). Full throughput is one pair per cycle.
- Entries left in a FIFO after a batch remain for the next batch.

Decomposition:
- Shared package:
  - DATA_W = 16 (shared with the fixed-point add/sub and multiply units).
  - State enum {IDLE, RUN, DONE}.
- Sub-module loss_pair_fifo (DEPTH, DATA_W): synchronous FIFO with full, empty and overflow strobe, instantiated twice.

Test Plan:
- Batch 4, inv 0x0080. Push H = {0x0100, 0x0200, 0xFF00, 0x0080} and Y = {0x0080, 0x0200, 0x0100, 0x0000} before start.
  -> 4 consecutive valid_out pairs in order; done_out asserted with the 4th pair; inv out = 0x0080.
- Y lags: H pushed at t0..t2, Y pushed at t10..t12, batch 3.
  -> first valid_out at t12, then one per cycle; no pair before Y arrives.
- Fill H FIFO with 8 entries, then push a 9th.
  -> h_ready_out=0 after the 8th; 9th dropped; overflow_err_out=1 until rst; only the 8 stored values are issued.
- start_in with batch_size=0, and cfg_load_in during RUN.
  -> state stays IDLE in the first case; in the second, inv and batch size stay unchanged mid-batch.
- Assert rst mid-batch (2 of 4 pairs issued, 3 entries queued).
  -> next cycle all outputs 0, FIFOs empty, state IDLE; a new batch of 2 issues only newly pushed data.
- Batch 2 with 5 H and 5 Y queued, then start again.
  -> batch 1 issues pairs 0-1; batch 2 issues pairs 2-3; 1 entry remains in each FIFO.
